// File: rtl/cpu_register_file.sv
// CPU programmer-visible register file: A, B, X, Y, SP and flags, with
// memory-indirect operands and pointer post-increment, one access per microcode step.

package cpu_types_pkg;

    typedef enum logic [1:0] {
        NONE,
        REG_FETCH,
        REG_WRITE
    } microcode_cycle;

    typedef enum logic [4:0] {
        REG_A,
        REG_B,
        REG_XL,
        REG_XH,
        REG_XP,
        REG_YL,
        REG_YH,
        REG_YP,
        REG_SPL,
        REG_SPH,
        REG_FLAGS,
        REG_MX,
        REG_MY,
        REG_MSP,
        REG_MN,
        REG_IMML,
        REG_IMMH,
        REG_IMM_ADDR_L,
        REG_IMM_ADDR_H,
        REG_IMM_ADDR_P,
        REG_HARDCODED_1,
        REG_ALU,
        REG_ALU_WITH_FLAGS,
        REG_TEMPA,
        REG_TEMPB,
        REG_PCSL,
        REG_PCSH,
        REG_PCP
    } reg_type;

    typedef enum logic [1:0] {
        REG_NONE,
        REG_XHL,
        REG_YHL,
        REG_SP
    } reg_inc_type;

    // Immediate-addressed operands pick A/B/MX/MY from a 2-bit field of the opcode.
    function automatic reg_type imm_addressed_reg(input reg_type sel, input logic [5:0] imm);
        logic [1:0] code;
        reg_type    res;
        code = 2'd0;
        res  = sel;
        case (sel)
            REG_IMM_ADDR_L: code = imm[1:0];
            REG_IMM_ADDR_H: code = imm[3:2];
            REG_IMM_ADDR_P: code = imm[5:4];
            default:        code = 2'd0;
        endcase
        if (sel inside {REG_IMM_ADDR_L, REG_IMM_ADDR_H, REG_IMM_ADDR_P}) begin
            case (code)
                2'd0:    res = REG_A;
                2'd1:    res = REG_B;
                2'd2:    res = REG_MX;
                default: res = REG_MY;
            endcase
        end
        return res;
    endfunction

endpackage

module cpu_register_file
    import cpu_types_pkg::*;
#(
    parameter int unsigned RAM_ADDR_W = 12
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_en,
    input  microcode_cycle        cycle,
    input  reg_type               read_sel,
    input  reg_type               write_sel,
    input  logic [3:0]            write_data,
    input  logic [7:0]            immed,
    input  reg_inc_type           inc_sel,
    input  logic                  inc_en,
    input  logic                  inc_down,
    input  logic [3:0]            flags_in,
    input  logic                  flags_we,
    output logic [3:0]            read_data,
    output logic                  read_valid,
    output logic [3:0]            flags,
    output logic [RAM_ADDR_W-1:0] mem_addr,
    input  logic [3:0]            mem_read_data,
    output logic                  mem_write_en,
    output logic [3:0]            mem_write_data
);

    localparam int unsigned DW  = 4;
    localparam int unsigned PW  = 12;
    localparam int unsigned SPW = 8;

    logic [DW-1:0]  a_q, b_q;
    logic [PW-1:0]  x_q, y_q;
    logic [SPW-1:0] sp_q;
    logic [DW-1:0]  hold_q;
    logic           mem_src_q;
    logic           pend_q;

    reg_type        rsel, wsel;
    logic           do_fetch, do_write;
    logic           fetch_is_mem, write_is_mem;
    logic [PW-1:0]  fetch_addr, write_addr;
    logic [DW-1:0]  fetch_val;
    logic [DW-1:0]  a_d, b_d, flags_d;
    logic [PW-1:0]  x_wr, y_wr, x_d, y_d;
    logic [SPW-1:0] sp_wr, sp_d;

    function automatic logic is_mem_sel(input reg_type sel);
        return sel inside {REG_MX, REG_MY, REG_MSP, REG_MN};
    endfunction

    // Addresses always come from the pointer values held before this step's updates.
    function automatic logic [PW-1:0] ptr_addr(input reg_type sel, input logic [PW-1:0] x,
                                               input logic [PW-1:0] y, input logic [SPW-1:0] sp,
                                               input logic [3:0] imm_lo);
        logic [PW-1:0] addr;
        case (sel)
            REG_MX:  addr = x;
            REG_MY:  addr = y;
            REG_MSP: addr = {4'h0, sp};
            REG_MN:  addr = {8'h00, imm_lo};
            default: addr = '0;
        endcase
        return addr;
    endfunction

    assign rsel         = imm_addressed_reg(read_sel, immed[5:0]);
    assign wsel         = imm_addressed_reg(write_sel, immed[5:0]);
    assign do_fetch     = clk_en && (cycle == REG_FETCH);
    assign do_write     = clk_en && (cycle == REG_WRITE);
    assign fetch_is_mem = is_mem_sel(rsel);
    assign write_is_mem = is_mem_sel(wsel);
    assign fetch_addr   = ptr_addr(rsel, x_q, y_q, sp_q, immed[3:0]);
    assign write_addr   = ptr_addr(wsel, x_q, y_q, sp_q, immed[3:0]);

    // Fetch source mux; sources owned by other blocks read as zero.
    always_comb begin
        fetch_val = '0;
        case (rsel)
            REG_A:           fetch_val = a_q;
            REG_B:           fetch_val = b_q;
            REG_XL:          fetch_val = x_q[3:0];
            REG_XH:          fetch_val = x_q[7:4];
            REG_XP:          fetch_val = x_q[11:8];
            REG_YL:          fetch_val = y_q[3:0];
            REG_YH:          fetch_val = y_q[7:4];
            REG_YP:          fetch_val = y_q[11:8];
            REG_SPL:         fetch_val = sp_q[3:0];
            REG_SPH:         fetch_val = sp_q[7:4];
            REG_FLAGS:       fetch_val = flags;
            REG_IMML:        fetch_val = immed[3:0];
            REG_IMMH:        fetch_val = immed[7:4];
            REG_HARDCODED_1: fetch_val = DW'(1);
            default:         fetch_val = '0;
        endcase
    end

    // Register write first, then pointer increment on the written value.
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        x_wr    = x_q;
        y_wr    = y_q;
        sp_wr   = sp_q;
        flags_d = flags;
        if (do_write) begin
            case (wsel)
                REG_A:     a_d          = write_data;
                REG_B:     b_d          = write_data;
                REG_XL:    x_wr[3:0]    = write_data;
                REG_XH:    x_wr[7:4]    = write_data;
                REG_XP:    x_wr[11:8]   = write_data;
                REG_YL:    y_wr[3:0]    = write_data;
                REG_YH:    y_wr[7:4]    = write_data;
                REG_YP:    y_wr[11:8]   = write_data;
                REG_SPL:   sp_wr[3:0]   = write_data;
                REG_SPH:   sp_wr[7:4]   = write_data;
                REG_FLAGS: flags_d      = write_data;
                default:   ;
            endcase
        end
        if (clk_en && flags_we) begin
            flags_d = flags_in;
        end
        x_d  = x_wr;
        y_d  = y_wr;
        sp_d = sp_wr;
        if (clk_en && inc_en) begin
            case (inc_sel)
                REG_XHL: x_d[7:0] = x_wr[7:0] + 8'd1;
                REG_YHL: y_d[7:0] = y_wr[7:0] + 8'd1;
                REG_SP:  sp_d     = inc_down ? (sp_wr - 8'd1) : (sp_wr + 8'd1);
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            a_q            <= '0;
            b_q            <= '0;
            x_q            <= '0;
            y_q            <= '0;
            sp_q           <= '0;
            flags          <= '0;
            hold_q         <= '0;
            mem_src_q      <= 1'b0;
            pend_q         <= 1'b0;
            read_data      <= '0;
            read_valid     <= 1'b0;
            mem_addr       <= '0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
        end else begin
            read_valid   <= 1'b0;
            mem_write_en <= 1'b0;
            if (clk_en) begin
                a_q    <= a_d;
                b_q    <= b_d;
                x_q    <= x_d;
                y_q    <= y_d;
                sp_q   <= sp_d;
                flags  <= flags_d;
                pend_q <= do_fetch;
                // Complete the fetch issued on the previous step; RAM data has settled by now.
                if (pend_q) begin
                    read_data  <= mem_src_q ? mem_read_data : hold_q;
                    read_valid <= 1'b1;
                end
                if (do_fetch) begin
                    hold_q    <= fetch_val;
                    mem_src_q <= fetch_is_mem;
                    if (fetch_is_mem) begin
                        mem_addr <= RAM_ADDR_W'(fetch_addr);
                    end
                end
                if (do_write && write_is_mem) begin
                    mem_addr       <= RAM_ADDR_W'(write_addr);
                    mem_write_data <= write_data;
                    mem_write_en   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_cpu_register_file.sv
// Randomised and directed checks of cpu_register_file against a behavioural
// model of the architectural registers and data RAM.

module tb_cpu_register_file;
    import cpu_types_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    logic           clk_en;
    microcode_cycle cycle;
    reg_type        read_sel, write_sel;
    logic [3:0]     write_data;
    logic [7:0]     immed;
    reg_inc_type    inc_sel;
    logic           inc_en, inc_down;
    logic [3:0]     flags_in;
    logic           flags_we;
    logic [3:0]     read_data;
    logic           read_valid;
    logic [3:0]     flags;
    logic [11:0]    mem_addr;
    logic [3:0]     mem_read_data;
    logic           mem_write_en;
    logic [3:0]     mem_write_data;

    always #5 clk = ~clk;

    cpu_register_file #(.RAM_ADDR_W(12)) dut (
        .clk(clk), .reset(reset), .clk_en(clk_en), .cycle(cycle),
        .read_sel(read_sel), .write_sel(write_sel), .write_data(write_data),
        .immed(immed), .inc_sel(inc_sel), .inc_en(inc_en), .inc_down(inc_down),
        .flags_in(flags_in), .flags_we(flags_we), .read_data(read_data),
        .read_valid(read_valid), .flags(flags), .mem_addr(mem_addr),
        .mem_read_data(mem_read_data), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data)
    );

    // Data RAM with one clk read latency.
    logic [3:0] ram [4096];
    logic       init_en = 1'b0;
    always @(posedge clk) begin
        if (init_en) begin
            for (int i = 0; i < 4096; i++) ram[i] <= 4'((i * 7 + 3) % 16);
        end else if (mem_write_en) begin
            ram[mem_addr] <= mem_write_data;
        end
        mem_read_data <= ram[mem_addr];
    end

    int checks = 0;
    int errors = 0;

    // Reference model state.
    int         m_a, m_b, m_x, m_y, m_sp, m_fl;
    int         m_ram [4096];
    bit         m_pend;
    int         m_pend_val;
    logic       exp_rv, exp_we;
    logic [3:0] exp_rd, exp_wd;
    logic [11:0] exp_ma;

    logic       obs_rv, obs_we, obs_rv2, obs_we2;
    logic [3:0] obs_rd, obs_wd, obs_fl;
    logic [11:0] obs_ma;

    function automatic reg_type resolve(input reg_type s, input int imm);
        int k, code;
        if (s == REG_IMM_ADDR_L) k = 0;
        else if (s == REG_IMM_ADDR_H) k = 1;
        else if (s == REG_IMM_ADDR_P) k = 2;
        else return s;
        code = (imm >> (2 * k)) % 4;
        case (code)
            0:       return REG_A;
            1:       return REG_B;
            2:       return REG_MX;
            default: return REG_MY;
        endcase
    endfunction

    function automatic bit is_mem_ref(input reg_type s);
        return (s == REG_MX) || (s == REG_MY) || (s == REG_MSP) || (s == REG_MN);
    endfunction

    function automatic int maddr(input reg_type s, input int imm);
        case (s)
            REG_MX:  return m_x;
            REG_MY:  return m_y;
            REG_MSP: return m_sp;
            REG_MN:  return imm % 16;
            default: return 0;
        endcase
    endfunction

    function automatic int rval(input reg_type s, input int imm);
        case (s)
            REG_A:           return m_a;
            REG_B:           return m_b;
            REG_XL:          return m_x % 16;
            REG_XH:          return (m_x / 16) % 16;
            REG_XP:          return m_x / 256;
            REG_YL:          return m_y % 16;
            REG_YH:          return (m_y / 16) % 16;
            REG_YP:          return m_y / 256;
            REG_SPL:         return m_sp % 16;
            REG_SPH:         return m_sp / 16;
            REG_FLAGS:       return m_fl;
            REG_IMML:        return imm % 16;
            REG_IMMH:        return imm / 16;
            REG_HARDCODED_1: return 1;
            REG_MX, REG_MY, REG_MSP, REG_MN: return m_ram[maddr(s, imm)];
            default:         return 0;
        endcase
    endfunction

    task automatic apply_write(input reg_type s, input int d, input int imm);
        int ad;
        case (s)
            REG_A:     m_a  = d;
            REG_B:     m_b  = d;
            REG_XL:    m_x  = m_x - (m_x % 16) + d;
            REG_XH:    m_x  = m_x - ((m_x / 16) % 16) * 16 + d * 16;
            REG_XP:    m_x  = (m_x % 256) + d * 256;
            REG_YL:    m_y  = m_y - (m_y % 16) + d;
            REG_YH:    m_y  = m_y - ((m_y / 16) % 16) * 16 + d * 16;
            REG_YP:    m_y  = (m_y % 256) + d * 256;
            REG_SPL:   m_sp = m_sp - (m_sp % 16) + d;
            REG_SPH:   m_sp = (m_sp % 16) + d * 16;
            REG_FLAGS: m_fl = d;
            REG_MX, REG_MY, REG_MSP, REG_MN: begin
                ad = maddr(s, imm);
                exp_we = 1'b1;
                exp_ma = 12'(ad);
                exp_wd = 4'(d);
                m_ram[ad] = d;
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_a = 0; m_b = 0; m_x = 0; m_y = 0; m_sp = 0; m_fl = 0;
        m_pend = 0; m_pend_val = 0;
        exp_rd = 4'h0; exp_ma = 12'h000; exp_wd = 4'h0; exp_rv = 1'b0; exp_we = 1'b0;
    endtask

    // One microcode step: clk_en high for one clk, low for the next.
    task automatic do_step(input microcode_cycle cyc, input reg_type rs, input reg_type ws,
                           input logic [3:0] wd, input logic [7:0] imm, input reg_inc_type isel,
                           input logic ie, input logic idn, input logic [3:0] fi, input logic fwe);
        reg_type rr, wr;
        bit np;
        @(negedge clk);
        cycle = cyc; read_sel = rs; write_sel = ws; write_data = wd; immed = imm;
        inc_sel = isel; inc_en = ie; inc_down = idn; flags_in = fi; flags_we = fwe; clk_en = 1'b1;
        rr = resolve(rs, int'(imm));
        wr = resolve(ws, int'(imm));
        exp_rv = m_pend;
        if (m_pend) exp_rd = 4'(m_pend_val);
        exp_we = 1'b0;
        np = 0;
        if (cyc == REG_FETCH) begin
            np = 1;
            m_pend_val = rval(rr, int'(imm));
            if (is_mem_ref(rr)) exp_ma = 12'(maddr(rr, int'(imm)));
        end
        if (cyc == REG_WRITE) apply_write(wr, int'(wd), int'(imm));
        if (fwe) m_fl = int'(fi);
        if (ie) begin
            case (isel)
                REG_XHL: m_x = (m_x / 256) * 256 + ((m_x % 256) + 1) % 256;
                REG_YHL: m_y = (m_y / 256) * 256 + ((m_y % 256) + 1) % 256;
                REG_SP:  m_sp = idn ? (m_sp + 255) % 256 : (m_sp + 1) % 256;
                default: ;
            endcase
        end
        m_pend = np;
        @(posedge clk);
        #1;
        obs_rv = read_valid; obs_rd = read_data; obs_we = mem_write_en;
        obs_ma = mem_addr; obs_wd = mem_write_data; obs_fl = flags;
        @(negedge clk);
        clk_en = 1'b0; inc_en = 1'b0; flags_we = 1'b0;
        @(posedge clk);
        #1;
        obs_rv2 = read_valid; obs_we2 = mem_write_en;
    endtask

    task automatic wr_reg(input reg_type s, input logic [3:0] d);
        do_step(REG_WRITE, REG_A, s, d, 8'h00, REG_NONE, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    task automatic rd_reg(input reg_type s, input logic [7:0] imm);
        do_step(REG_FETCH, s, REG_A, 4'h0, imm, REG_NONE, 1'b0, 1'b0, 4'h0, 1'b0);
    endtask

    // Reset with an active write/increment/flag load presented, to show reset priority.
    task automatic apply_reset();
        @(negedge clk);
        reset = 1'b1; clk_en = 1'b1; cycle = REG_WRITE; write_sel = REG_A; write_data = 4'hF;
        flags_we = 1'b1; flags_in = 4'hF; inc_en = 1'b1; inc_sel = REG_SP; inc_down = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        obs_rv = read_valid; obs_rd = read_data; obs_we = mem_write_en;
        obs_ma = mem_addr; obs_wd = mem_write_data; obs_fl = flags;
        @(negedge clk);
        reset = 1'b0; clk_en = 1'b0; flags_we = 1'b0; inc_en = 1'b0; cycle = NONE;
        model_reset();
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (obs_rd !== 4'h0) begin errors++; $display("FAIL reset_read_data: got %h want 0", obs_rd); end
        checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL reset_read_valid: got %b want 0", obs_rv); end
        checks++; if (obs_ma !== 12'h000) begin errors++; $display("FAIL reset_mem_addr: got %h want 000", obs_ma); end
        checks++; if (obs_we !== 1'b0 || obs_wd !== 4'h0) begin errors++; $display("FAIL reset_mem_write: got we=%b wd=%h want 0/0", obs_we, obs_wd); end
        checks++; if (obs_fl !== 4'h0) begin errors++; $display("FAIL reset_flags: got %h want 0", obs_fl); end
        // NONE steps with memory selectors must not strobe anything.
        for (int i = 0; i < 3; i++) begin
            do_step(NONE, REG_MX, REG_MSP, 4'(i + 1), 8'h00, REG_NONE, 1'b0, 1'b0, 4'h0, 1'b0);
            checks++; if (obs_we !== 1'b0 || obs_rv !== 1'b0) begin errors++; $display("FAIL none_step: got we=%b rv=%b want 0/0", obs_we, obs_rv); end
        end
    endtask

    task automatic test_write_fetch();
        wr_reg(REG_A, 4'hA);
        rd_reg(REG_A, 8'h00);
        rd_reg(REG_B, 8'h00);
        checks++; if (obs_rv !== 1'b1) begin errors++; $display("FAIL fetch_a_valid: got %b want 1", obs_rv); end
        checks++; if (obs_rd !== 4'hA) begin errors++; $display("FAIL fetch_a_data: got %h want a", obs_rd); end
        checks++; if (obs_rv2 !== 1'b0) begin errors++; $display("FAIL fetch_a_pulse: got %b want 0 on following clk", obs_rv2); end
    endtask

    task automatic test_mem_write();
        wr_reg(REG_XP, 4'h1); wr_reg(REG_XH, 4'h2); wr_reg(REG_XL, 4'h3);
        wr_reg(REG_MX, 4'h5);
        checks++; if (obs_we !== 1'b1 || obs_we2 !== 1'b0) begin errors++; $display("FAIL mx_write_strobe: got %b,%b want 1,0", obs_we, obs_we2); end
        checks++; if (obs_ma !== 12'h123) begin errors++; $display("FAIL mx_write_addr: got %h want 123", obs_ma); end
        checks++; if (obs_wd !== 4'h5) begin errors++; $display("FAIL mx_write_data: got %h want 5", obs_wd); end
        rd_reg(REG_MX, 8'h00);
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'h5) begin errors++; $display("FAIL mx_readback: got %h want 5", obs_rd); end
    endtask

    task automatic test_increment();
        wr_reg(REG_XP, 4'h3); wr_reg(REG_XH, 4'hF); wr_reg(REG_XL, 4'hF);
        do_step(REG_FETCH, REG_HARDCODED_1, REG_A, 4'h0, 8'h00, REG_XHL, 1'b1, 1'b0, 4'h0, 1'b0);
        rd_reg(REG_XP, 8'h00); rd_reg(REG_XH, 8'h00);
        checks++; if (obs_rd !== 4'h3) begin errors++; $display("FAIL xinc_xp: got %h want 3", obs_rd); end
        rd_reg(REG_XL, 8'h00);
        checks++; if (obs_rd !== 4'h0) begin errors++; $display("FAIL xinc_xh: got %h want 0", obs_rd); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'h0) begin errors++; $display("FAIL xinc_xl: got %h want 0", obs_rd); end
        wr_reg(REG_SPL, 4'h0); wr_reg(REG_SPH, 4'h0);
        do_step(REG_FETCH, REG_HARDCODED_1, REG_A, 4'h0, 8'h00, REG_SP, 1'b1, 1'b1, 4'h0, 1'b0);
        rd_reg(REG_SPL, 8'h00); rd_reg(REG_SPH, 8'h00);
        checks++; if (obs_rd !== 4'hF) begin errors++; $display("FAIL spdec_spl: got %h want f", obs_rd); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'hF) begin errors++; $display("FAIL spdec_sph: got %h want f", obs_rd); end
    endtask

    task automatic test_imm_addressed();
        wr_reg(REG_XP, 4'h0); wr_reg(REG_XH, 4'h4); wr_reg(REG_XL, 4'h5);
        wr_reg(REG_MX, 4'h7);
        wr_reg(REG_B, 4'hC);
        rd_reg(REG_IMM_ADDR_H, 8'h39);
        checks++; if (obs_ma !== 12'h045) begin errors++; $display("FAIL imm_h_addr: got %h want 045", obs_ma); end
        rd_reg(REG_IMM_ADDR_L, 8'h39);
        checks++; if (obs_rd !== 4'h7) begin errors++; $display("FAIL imm_h_data: got %h want 7", obs_rd); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'hC) begin errors++; $display("FAIL imm_l_data: got %h want c", obs_rd); end
    endtask

    task automatic test_write_inc_same();
        wr_reg(REG_XP, 4'h2); wr_reg(REG_XH, 4'h0); wr_reg(REG_XL, 4'hE);
        do_step(REG_WRITE, REG_A, REG_XL, 4'hF, 8'h00, REG_XHL, 1'b1, 1'b0, 4'h0, 1'b0);
        checks++; if (obs_we !== 1'b0) begin errors++; $display("FAIL winc_no_mem: got %b want 0", obs_we); end
        rd_reg(REG_XP, 8'h00); rd_reg(REG_XH, 8'h00);
        checks++; if (obs_rd !== 4'h2) begin errors++; $display("FAIL winc_xp: got %h want 2", obs_rd); end
        rd_reg(REG_XL, 8'h00);
        checks++; if (obs_rd !== 4'h1) begin errors++; $display("FAIL winc_xh: got %h want 1", obs_rd); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'h0) begin errors++; $display("FAIL winc_xl: got %h want 0", obs_rd); end
        do_step(REG_WRITE, REG_A, REG_MX, 4'h6, 8'h00, REG_XHL, 1'b1, 1'b0, 4'h0, 1'b0);
        checks++; if (obs_ma !== 12'h210) begin errors++; $display("FAIL winc_mx_addr: got %h want 210", obs_ma); end
    endtask

    task automatic test_flags();
        do_step(REG_WRITE, REG_A, REG_FLAGS, 4'h5, 8'h00, REG_NONE, 1'b0, 1'b0, 4'hA, 1'b1);
        checks++; if (obs_fl !== 4'hA) begin errors++; $display("FAIL flags_we_wins: got %h want a", obs_fl); end
        wr_reg(REG_FLAGS, 4'h3);
        checks++; if (obs_fl !== 4'h3) begin errors++; $display("FAIL flags_write: got %h want 3", obs_fl); end
        do_step(REG_FETCH, REG_FLAGS, REG_A, 4'h0, 8'h00, REG_NONE, 1'b0, 1'b0, 4'hC, 1'b1);
        checks++; if (obs_fl !== 4'hC) begin errors++; $display("FAIL flags_load: got %h want c", obs_fl); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'h3) begin errors++; $display("FAIL flags_fetch_old: got %h want 3", obs_rd); end
    endtask

    task automatic test_back_to_back();
        reg_type seq [6] = '{REG_SPL, REG_MSP, REG_IMMH, REG_MN, REG_A, REG_HARDCODED_1};
        for (int i = 0; i < 6; i++) begin
            rd_reg(seq[i], 8'hB6);
            checks++; if (obs_rv !== 1'b1 || obs_rd !== exp_rd || obs_rv2 !== 1'b0) begin
                errors++; $display("FAIL b2b_%0d: got rv=%b rd=%h rv2=%b want 1 %h 0", i, obs_rv, obs_rd, obs_rv2, exp_rd);
            end
        end
    endtask

    task automatic test_reset_pending();
        wr_reg(REG_A, 4'h9);
        rd_reg(REG_A, 8'h00);
        apply_reset();
        checks++; if (obs_rv !== 1'b0 || obs_fl !== 4'h0) begin errors++; $display("FAIL rst_pend: got rv=%b fl=%h want 0/0", obs_rv, obs_fl); end
        rd_reg(REG_A, 8'h00);
        checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL rst_discard: got %b want 0", obs_rv); end
        for (int s = 1; s <= 11; s++) begin
            rd_reg(reg_type'(5'(s)), 8'h00);
            checks++; if (obs_rd !== 4'h0 || obs_rv !== 1'b1) begin errors++; $display("FAIL rst_reg_%0d: got rd=%h rv=%b want 0/1", s - 1, obs_rd, obs_rv); end
        end
    endtask

    task automatic test_clk_en_low();
        logic [3:0] fl0;
        wr_reg(REG_A, 4'h6); wr_reg(REG_SPL, 4'h4); wr_reg(REG_FLAGS, 4'h9);
        fl0 = flags;
        @(negedge clk);
        clk_en = 1'b0; cycle = REG_WRITE; write_sel = REG_MX; write_data = 4'hF;
        flags_we = 1'b1; flags_in = 4'h0; inc_en = 1'b1; inc_sel = REG_SP; inc_down = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++; if (mem_write_en !== 1'b0 || read_valid !== 1'b0 || flags !== fl0) begin
                errors++; $display("FAIL en_low_%0d: got we=%b rv=%b fl=%h want 0 0 %h", i, mem_write_en, read_valid, flags, fl0);
            end
            @(negedge clk);
            cycle = (i % 2 == 0) ? REG_FETCH : REG_WRITE;
        end
        flags_we = 1'b0; inc_en = 1'b0;
        rd_reg(REG_A, 8'h00); rd_reg(REG_SPL, 8'h00);
        checks++; if (obs_rd !== 4'h6) begin errors++; $display("FAIL en_low_a: got %h want 6", obs_rd); end
        rd_reg(REG_HARDCODED_1, 8'h00);
        checks++; if (obs_rd !== 4'h4) begin errors++; $display("FAIL en_low_spl: got %h want 4", obs_rd); end
    endtask

    task automatic test_random();
        microcode_cycle cyc;
        for (int n = 0; n < 400; n++) begin
            cyc = ($urandom_range(0, 1) == 1) ? REG_FETCH : REG_WRITE;
            do_step(cyc, reg_type'(5'($urandom_range(0, 27))), reg_type'(5'($urandom_range(0, 27))),
                    4'($urandom_range(0, 15)), 8'($urandom_range(0, 255)),
                    reg_inc_type'(2'($urandom_range(0, 3))), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 3) == 0));
            checks++; if (obs_rv !== exp_rv || obs_rd !== exp_rd) begin errors++; $display("FAIL rnd_read_%0d: got rv=%b rd=%h want %b %h", n, obs_rv, obs_rd, exp_rv, exp_rd); end
            checks++; if (obs_we !== exp_we || obs_ma !== exp_ma || obs_wd !== exp_wd) begin
                errors++; $display("FAIL rnd_mem_%0d: got we=%b a=%h d=%h want %b %h %h", n, obs_we, obs_ma, obs_wd, exp_we, exp_ma, exp_wd);
            end
            checks++; if (obs_fl !== 4'(m_fl)) begin errors++; $display("FAIL rnd_flags_%0d: got %h want %h", n, obs_fl, 4'(m_fl)); end
            checks++; if (obs_rv2 !== 1'b0 || obs_we2 !== 1'b0) begin errors++; $display("FAIL rnd_pulse_%0d: got rv=%b we=%b want 0/0", n, obs_rv2, obs_we2); end
        end
    endtask

    initial begin
        reset = 1'b0; clk_en = 1'b0; cycle = NONE; read_sel = REG_A; write_sel = REG_A;
        write_data = 4'h0; immed = 8'h00; inc_sel = REG_NONE; inc_en = 1'b0; inc_down = 1'b0;
        flags_in = 4'h0; flags_we = 1'b0;
        for (int i = 0; i < 4096; i++) m_ram[i] = (i * 7 + 3) % 16;
        @(negedge clk);
        init_en = 1'b1;
        @(negedge clk);
        init_en = 1'b0;
        test_reset();
        test_write_fetch();
        test_mem_write();
        test_increment();
        test_imm_addressed();
        test_write_inc_same();
        test_flags();
        test_back_to_back();
        test_reset_pending();
        test_clk_en_low();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
